// File: rtl/tdc_uart_sched.sv
// ---------------------------------------------------------------------------
// tdc_uart_sched
//   Schedules the three producers of 40-bit UART records: TDC measurements
//   (buffered in a small FIFO), one-shot host status records and periodic
//   heartbeats. Sources are served in fixed priority order and every dispatch
//   is rate limited to one per CLKS_PER_TX clocks.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   meas_data/valid measurement word and single-cycle strobe from tdc_core
//   stat_data/req   status record and single-cycle send request
//   stat_ack        pulses when the status record is handed to the UART
//   uart_busy       busy flag from uart_tx
//   uart_data       word presented to uart_tx, stable until the next grant
//   uart_start      single-cycle dispatch strobe to uart_tx
//   fifo_level      measurement FIFO occupancy, 0..DEPTH
//   drop_count      measurements lost to FIFO overflow, saturates at 255
// ---------------------------------------------------------------------------
module tdc_uart_sched #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int TX_RATE_HZ = 20,
   parameter int HB_DIV     = 100,
   parameter int DEPTH      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [39:0] meas_data,
   input  logic        meas_valid,
   input  logic [39:0] stat_data,
   input  logic        stat_req,
   output logic        stat_ack,
   input  logic        uart_busy,
   output logic [39:0] uart_data,
   output logic        uart_start,
   output logic [4:0]  fifo_level,
   output logic [7:0]  drop_count
);

   localparam int CLKS_PER_TX = CLK_FREQ / TX_RATE_HZ;
   localparam int RW = $clog2(CLKS_PER_TX + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

   localparam logic [RW-1:0] RATE_FULL  = RW'(CLKS_PER_TX);
   localparam logic [RW-1:0] DIV_LAST   = RW'(CLKS_PER_TX - 1);
   localparam logic [SW-1:0] SLOT_LAST  = SW'((HB_DIV > 0) ? HB_DIV - 1 : 0);
   localparam logic [4:0]    LEVEL_FULL = 5'(DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAITB = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]    state;
   logic [1:0]    wait_cnt;
   logic [RW-1:0] rate_cnt;
   logic [RW-1:0] div_cnt;
   logic [SW-1:0] hb_slot;
   logic          hb_pend;
   logic          stat_pend;
   logic [39:0]   stat_buf;

   logic [39:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic can_tx, grant, sel_stat, sel_meas, sel_hb;
   logic fifo_empty, fifo_full, pop, push_ok, drop;

   assign can_tx     = (rate_cnt >= RATE_FULL);
   assign fifo_empty = (fifo_level == 5'd0);
   assign fifo_full  = (fifo_level == LEVEL_FULL);

   // Fixed priority: status, then measurements, then heartbeat.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned (which would infer a latch).
      sel_stat = 1'b0;
      sel_meas = 1'b0;
      sel_hb   = 1'b0;
      if (stat_pend)        sel_stat = 1'b1;
      else if (!fifo_empty) sel_meas = 1'b1;
      else if (hb_pend)     sel_hb   = 1'b1;
   end

   assign grant   = (state == ST_IDLE) && can_tx && !uart_busy &&
                    (sel_stat || sel_meas || sel_hb);
   assign pop     = grant && sel_meas;
   // A push into a full FIFO still succeeds when a pop frees a slot this cycle.
   assign push_ok = meas_valid && (!fifo_full || pop);
   assign drop    = meas_valid && fifo_full && !pop;

   // Rate limiter. The grant cycle counts as the first elapsed cycle, so with
   // the fixed grant-to-start latency consecutive uart_start pulses land
   // exactly CLKS_PER_TX clocks apart.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rate_cnt <= RATE_FULL;
      end else if (grant) begin
         rate_cnt <= RW'(1);
      end else if (!can_tx) begin
         rate_cnt <= rate_cnt + 1'b1;
      end
   end

   // Heartbeat: a free-running divider marks slot boundaries every
   // CLKS_PER_TX clocks; every HB_DIV slots a heartbeat becomes pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         hb_slot <= '0;
         hb_pend <= 1'b0;
      end else begin
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
         if (grant && sel_hb) hb_pend <= 1'b0;
         if (HB_DIV > 0 && div_cnt == DIV_LAST) begin
            if (hb_slot == SLOT_LAST) begin
               hb_slot <= '0;
               hb_pend <= 1'b1;
            end else begin
               hb_slot <= hb_slot + 1'b1;
            end
         end
      end
   end

   // Status holding register: the latest request wins; a request arriving in
   // the same cycle its predecessor is granted stays pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_pend <= 1'b0;
         stat_buf  <= '0;
      end else if (stat_req) begin
         stat_pend <= 1'b1;
         stat_buf  <= stat_data;
      end else if (grant && sel_stat) begin
         stat_pend <= 1'b0;
      end
   end

   // NOTE: the FIFO storage has no reset; only the pointers and level must be
   // cleared for the FIFO to read as empty, and a resettable RAM costs logic.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= meas_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         drop_count <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         fifo_level <= fifo_level + 5'(push_ok) - 5'(pop);
         if (drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
      end
   end

   // Dispatch FSM. uart_start and stat_ack are single-cycle pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         uart_data  <= '0;
         uart_start <= 1'b0;
         stat_ack   <= 1'b0;
      end else begin
         uart_start <= 1'b0;
         stat_ack   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  if (sel_stat)      uart_data <= stat_buf;
                  else if (sel_meas) uart_data <= mem[rd_ptr];
                  else               uart_data <= {8'hA5, 16'h0000, 3'b000,
                                                   fifo_level, drop_count};
                  stat_ack <= sel_stat;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               uart_start <= 1'b1;
               wait_cnt   <= '0;
               state      <= ST_WAITB;
            end
            ST_WAITB: begin
               // A transmitter that never raises busy does not hang the
               // scheduler; the word is treated as sent.
               if (uart_busy)             state <= ST_DONE;
               else if (wait_cnt == 2'd3) state <= ST_IDLE;
               else                       wait_cnt <= wait_cnt + 1'b1;
            end
            default: begin
               if (!uart_busy) state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tdc_uart_sched.sv
// ---------------------------------------------------------------------------
// tb_tdc_uart_sched
//   Directed and randomized bench for tdc_uart_sched with CLKS_PER_TX=10,
//   HB_DIV=3, DEPTH=4. A second instance with HB_DIV=0 must stay silent.
//   A simple uart_tx model raises busy one cycle after uart_start for five
//   cycles; it can be disabled to exercise the busy timeout.
// ---------------------------------------------------------------------------
module tb_tdc_uart_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [39:0] meas_data = '0;
   logic        meas_valid = 1'b0;
   logic [39:0] stat_data = '0;
   logic        stat_req = 1'b0;
   logic        stat_ack;
   logic        uart_busy;
   logic [39:0] uart_data;
   logic        uart_start;
   logic [4:0]  fifo_level;
   logic [7:0]  drop_count;

   logic        nh_ack, nh_start;
   logic [39:0] nh_data;
   logic [4:0]  nh_level;
   logic [7:0]  nh_drop;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int nohb_starts = 0;
   bit uart_en = 1'b1;
   int bcnt = 0;

   int          start_cyc[$];
   logic [39:0] start_data[$];
   int          ack_cyc[$];

   always #5 clk = ~clk;

   tdc_uart_sched #(.CLK_FREQ(1000), .TX_RATE_HZ(100), .HB_DIV(3), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .meas_data(meas_data), .meas_valid(meas_valid),
      .stat_data(stat_data), .stat_req(stat_req), .stat_ack(stat_ack),
      .uart_busy(uart_busy), .uart_data(uart_data), .uart_start(uart_start),
      .fifo_level(fifo_level), .drop_count(drop_count));

   tdc_uart_sched #(.CLK_FREQ(1000), .TX_RATE_HZ(100), .HB_DIV(0), .DEPTH(4)) dut_nohb (
      .clk(clk), .rst(rst), .meas_data(40'h0), .meas_valid(1'b0),
      .stat_data(40'h0), .stat_req(1'b0), .stat_ack(nh_ack),
      .uart_busy(1'b0), .uart_data(nh_data), .uart_start(nh_start),
      .fifo_level(nh_level), .drop_count(nh_drop));

   // uart_tx model: busy for 5 cycles starting one cycle after uart_start.
   always @(posedge clk or posedge rst) begin
      if (rst)                          bcnt <= 0;
      else if (uart_en && uart_start)   bcnt <= 5;
      else if (bcnt != 0)               bcnt <= bcnt - 1;
   end
   assign uart_busy = (bcnt != 0);

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (uart_start) begin
         start_cyc.push_back(cyc);
         start_data.push_back(uart_data);
      end
      if (stat_ack) ack_cyc.push_back(cyc);
      if (nh_start) nohb_starts++;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      start_cyc.delete();
      start_data.delete();
      ack_cyc.delete();
      nohb_starts = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      meas_valid = 1'b0;
      stat_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic wait_starts(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (start_cyc.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, 64'(start_cyc.size() >= n), 64'd1);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic push_meas(input logic [39:0] d);
      meas_valid = 1'b1;
      meas_data  = d;
      @(negedge clk);
      meas_valid = 1'b0;
   endtask

   initial begin
      int k, s0, n0, r, gap;
      logic [39:0] d, exp_w;
      logic [39:0] exp_q[$];

      // ---------------- reset values
      @(negedge clk);
      @(negedge clk);
      check("rst_uart_data",  uart_data, 40'h0);
      check("rst_uart_start", uart_start, 1'b0);
      check("rst_stat_ack",   stat_ack, 1'b0);
      check("rst_fifo_level", fifo_level, 5'd0);
      check("rst_drop_count", drop_count, 8'd0);
      rst = 1'b0;
      clear_logs();

      // ---------------- single measurement: push edge +2 = start
      do_reset();
      k = cyc;
      push_meas(40'h00_0000_1234);
      wait_starts("single_seen", 1, 20);
      check("single_data", start_data[0], 40'h0000001234);
      check("single_latency", 64'(start_cyc[0] - k), 64'd3);
      check("single_level", fifo_level, 5'd0);
      check("single_no_ack", 64'(ack_cyc.size()), 64'd0);

      // ---------------- burst of 6: one dispatched, four stored, one dropped
      do_reset();
      for (int i = 0; i < 6; i++) begin
         meas_valid = 1'b1;
         meas_data  = 40'h10 + 40'(i);
         @(negedge clk);
      end
      meas_valid = 1'b0;
      check("burst_level", fifo_level, 5'd4);
      check("burst_drop", drop_count, 8'd1);
      wait_starts("burst_seen", 5, 80);
      if (start_cyc.size() >= 5) begin
         for (int i = 0; i < 5; i++) check("burst_data", start_data[i], 40'h10 + 40'(i));
         for (int i = 1; i < 5; i++) check("burst_spacing", 64'(start_cyc[i] - start_cyc[i-1]), 64'd10);
      end

      // ---------------- status beats measurement; latest status wins
      do_reset();
      k = cyc;
      meas_valid = 1'b1; meas_data = 40'h77;
      stat_req   = 1'b1; stat_data = 40'hCAFE000001;
      @(negedge clk);
      meas_valid = 1'b0; stat_req = 1'b0;
      wait_starts("stat_seen", 2, 30);
      check("stat_first", start_data[0], 40'hCAFE000001);
      check("stat_ack_cyc", 64'(ack_cyc.size() == 1 && ack_cyc[0] == k + 2), 64'd1);
      check("stat_meas_second", start_data[1], 40'h77);
      check("stat_meas_spacing", 64'(start_cyc[1] - start_cyc[0]), 64'd10);
      stat_req = 1'b1; stat_data = 40'h11_1111_1111;
      @(negedge clk);
      stat_data = 40'h22_2222_2222;
      @(negedge clk);
      stat_req = 1'b0;
      wait_starts("stat_latest_seen", 3, 20);
      check("stat_latest_data", start_data[2], 40'h2222222222);
      wait_cyc(cyc + 3);
      check("stat_ack_count", 64'(ack_cyc.size()), 64'd2);

      // ---------------- heartbeat with no traffic
      do_reset();
      r = cyc;
      wait_starts("hb_first_seen", 1, 60);
      check("hb_first_data", start_data[0], 40'hA500000000);
      check("hb_first_time", 64'(start_cyc[0] - r >= 30 && start_cyc[0] - r <= 34), 64'd1);
      wait_starts("hb_second_seen", 2, 60);
      check("hb_second_data", start_data[1], 40'hA500000000);
      check("hb_period", 64'(start_cyc[1] - start_cyc[0]), 64'd30);
      check("hb_div0_silent", 64'(nohb_starts), 64'd0);

      // ---------------- full FIFO: push coinciding with pop, then saturation
      do_reset();
      for (int i = 0; i < 5; i++) begin
         meas_valid = 1'b1;
         meas_data  = 40'h20 + 40'(i);
         @(negedge clk);
      end
      meas_valid = 1'b0;
      check("full_level", fifo_level, 5'd4);
      wait_starts("full_first_seen", 1, 10);
      s0 = start_cyc[0];
      wait_cyc(s0 + 8);
      push_meas(40'h2F);
      check("full_pushpop_level", fifo_level, 5'd4);
      check("full_pushpop_drop", drop_count, 8'd0);
      meas_valid = 1'b1; meas_data = 40'h30;
      repeat (300) @(negedge clk);
      meas_valid = 1'b0;
      check("sat_drop", drop_count, 8'd255);
      k = 0;
      while (fifo_level != 5'd0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("sat_drained", fifo_level, 5'd0);
      n0 = start_cyc.size();
      wait_starts("sat_hb_seen", n0 + 2, 40);
      check("sat_hb_data", start_data[n0 + 1], 40'hA5000000FF);

      // ---------------- reset while DONE with three words queued
      do_reset();
      for (int i = 0; i < 4; i++) push_meas(40'h40 + 40'(i));
      wait_starts("mid_first_seen", 1, 10);
      wait_cyc(start_cyc[0] + 4);
      check("mid_pre_level", fifo_level, 5'd3);
      rst = 1'b1;
      #1;
      check("mid_rst_data", uart_data, 40'h0);
      check("mid_rst_start", uart_start, 1'b0);
      check("mid_rst_level", fifo_level, 5'd0);
      @(negedge clk);
      rst = 1'b0;
      clear_logs();
      k = cyc;
      push_meas(40'h99);
      wait_starts("mid_after_seen", 1, 20);
      check("mid_after_data", start_data[0], 40'h99);
      check("mid_after_latency", 64'(start_cyc[0] - k), 64'd3);

      // ---------------- busy never rises: timeout, word not resent
      uart_en = 1'b0;
      do_reset();
      r = cyc;
      push_meas(40'h51);
      push_meas(40'h52);
      wait_starts("to_seen", 2, 30);
      check("to_second_data", start_data[1], 40'h52);
      check("to_spacing", 64'(start_cyc[1] - start_cyc[0]), 64'd10);
      wait_cyc(r + 25);
      check("to_count", 64'(start_cyc.size()), 64'd2);
      uart_en = 1'b1;

      // ---------------- randomized measurements against a scoreboard
      do_reset();
      for (int i = 0; i < 25; i++) begin
         d = {1'b0, 7'($urandom_range(0, 127)), 32'($urandom)};
         exp_q.push_back(d);
         push_meas(d);
         gap = int'($urandom_range(12, 30));
         repeat (gap) @(negedge clk);
      end
      repeat (40) @(negedge clk);
      for (int i = 0; i < start_data.size(); i++) begin
         if (start_data[i][39:32] == 8'hA5) begin
            check("rand_hb", start_data[i], 40'hA500000000);
         end else begin
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 40'hFF_FFFF_FFFF;
            check("rand_meas", start_data[i], exp_w);
         end
         if (i > 0) check("rand_gap", 64'(start_cyc[i] - start_cyc[i-1] >= 10), 64'd1);
      end
      check("rand_all_sent", 64'(exp_q.size()), 64'd0);
      check("rand_no_drop", drop_count, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
